// File: rtl/usb_time_endpoint_pkg.sv
// Shared types for the time IN endpoint: BCD digits, snapshot layout,
// FSM states and the payload byte mux.
package usb_time_endpoint_pkg;

  typedef logic [3:0] bcd_t;

  localparam int EP_TIME_LEN = 8;
  localparam int ST_SYNC     = 7;
  localparam int ST_ERR      = 6;

  typedef enum logic {
    SNAP,
    SEND
  } ep_time_state_t;

  typedef struct packed {
    bcd_t [1:0] year;
    bcd_t [1:0] month;
    bcd_t [1:0] day;
    logic [2:0] dow;
    bcd_t [1:0] hour;
    bcd_t [1:0] minute;
    bcd_t [1:0] second;
    logic       sync;
    logic       err;
  } ep_snap_t;

  function automatic logic [7:0] ep_time_byte(
    input ep_snap_t   s,
    input logic [2:0] i,
    input logic [3:0] seq
  );
    logic [7:0] b;
    b = '0;
    case (i)
      3'd0: b = {s.year[1], s.year[0]};
      3'd1: b = {s.month[1], s.month[0]};
      3'd2: b = {s.day[1], s.day[0]};
      3'd3: b = {5'b0, s.dow};
      3'd4: b = {s.hour[1], s.hour[0]};
      3'd5: b = {s.minute[1], s.minute[0]};
      3'd6: b = {s.second[1], s.second[0]};
      default: begin
        b[ST_SYNC] = s.sync;
        b[ST_ERR]  = s.err;
        b[3:0]     = seq;
      end
    endcase
    return b;
  endfunction

endpackage

// File: rtl/usb_time_endpoint.sv
// Time-of-day IN endpoint: snapshots the clock once per packet and
// streams it as 8 bytes to usb_sie, replaying the snapshot on abort.
module usb_time_endpoint
  import usb_time_endpoint_pkg::*;
#(
  parameter int SEQ_W = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  bcd_t [1:0] year,
  input  bcd_t [1:0] month,
  input  bcd_t [1:0] day,
  input  logic [2:0] day_of_week,
  input  bcd_t [1:0] hour,
  input  bcd_t [1:0] minute,
  input  bcd_t [1:0] second,
  input  logic       dcf77_sync,
  input  logic       dcf77_error,
  input  logic       abort,
  output logic [7:0] endpi_data,
  output logic       endpi_valid,
  output logic       endpi_crc16,
  input  logic       endpi_ready
);

  localparam logic [2:0] LAST = 3'(EP_TIME_LEN - 1);

  ep_time_state_t state, state_d;
  ep_snap_t       snap, snap_d, live;
  logic [2:0]     idx, idx_d;
  logic [SEQ_W-1:0] seq, seq_d;
  logic [3:0]     seq_ext;
  logic [7:0]     data_q, data_d;
  logic           crc_q, crc_d;

  always_comb begin
    live.year   = year;
    live.month  = month;
    live.day    = day;
    live.dow    = day_of_week;
    live.hour   = hour;
    live.minute = minute;
    live.second = second;
    live.sync   = dcf77_sync;
    live.err    = dcf77_error;
  end

  always_comb begin
    seq_ext = '0;
    seq_ext[SEQ_W-1:0] = seq;
  end

  // abort wins over a same-cycle transfer so the packet replays intact
  always_comb begin
    state_d = state;
    snap_d  = snap;
    idx_d   = idx;
    seq_d   = seq;
    data_d  = data_q;
    crc_d   = crc_q;
    unique case (state)
      SNAP: begin
        snap_d  = live;
        idx_d   = '0;
        state_d = SEND;
        data_d  = ep_time_byte(live, 3'd0, seq_ext);
        crc_d   = 1'b0;
      end
      SEND: begin
        if (abort) begin
          idx_d  = '0;
          data_d = ep_time_byte(snap, 3'd0, seq_ext);
          crc_d  = 1'b0;
        end else if (endpi_ready) begin
          if (idx == LAST) begin
            seq_d   = seq + 1'b1;
            idx_d   = '0;
            state_d = SNAP;
            data_d  = '0;
            crc_d   = 1'b0;
          end else begin
            idx_d  = idx + 3'd1;
            data_d = ep_time_byte(snap, idx + 3'd1, seq_ext);
            crc_d  = (idx + 3'd1 == LAST);
          end
        end
      end
      default: state_d = SNAP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= SNAP;
      snap   <= '0;
      idx    <= '0;
      seq    <= '0;
      data_q <= '0;
      crc_q  <= 1'b0;
    end else begin
      state  <= state_d;
      snap   <= snap_d;
      idx    <= idx_d;
      seq    <= seq_d;
      data_q <= data_d;
      crc_q  <= crc_d;
    end
  end

  assign endpi_valid = (state == SEND);
  assign endpi_data  = data_q;
  assign endpi_crc16 = crc_q;

endmodule

// File: tb/tb_usb_time_endpoint.sv
// Bench for usb_time_endpoint: packet-level reference model,
// random stalls/aborts/time churn, two SEQ_W variants.
module tb_usb_time_endpoint;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] yr, mo, dy, hr, mi, sc;
  logic [2:0] dow;
  logic       sync, err, abort, ready;
  logic [7:0] data4, data2;
  logic       valid4, valid2, crc4, crc2;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  usb_time_endpoint #(.SEQ_W(4)) dut4 (
    .clk(clk), .rst(rst),
    .year(yr), .month(mo), .day(dy), .day_of_week(dow),
    .hour(hr), .minute(mi), .second(sc),
    .dcf77_sync(sync), .dcf77_error(err), .abort(abort),
    .endpi_data(data4), .endpi_valid(valid4),
    .endpi_crc16(crc4), .endpi_ready(ready)
  );

  usb_time_endpoint #(.SEQ_W(2)) dut2 (
    .clk(clk), .rst(rst),
    .year(yr), .month(mo), .day(dy), .day_of_week(dow),
    .hour(hr), .minute(mi), .second(sc),
    .dcf77_sync(sync), .dcf77_error(err), .abort(abort),
    .endpi_data(data2), .endpi_valid(valid2),
    .endpi_crc16(crc2), .endpi_ready(ready)
  );

  // reference model: one expected packet per snapshot
  logic [7:0] pkt4 [8];
  logic [7:0] pkt2 [8];
  bit m_valid = 0;
  bit m_rst = 0;
  int m_pos = 0;
  int m_seq = 0;
  bit churn = 0;
  int stall = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic rand_time();
    yr   = bcd($urandom_range(0, 99));
    mo   = bcd($urandom_range(1, 12));
    dy   = bcd($urandom_range(1, 31));
    dow  = 3'($urandom_range(0, 7));
    hr   = bcd($urandom_range(0, 23));
    mi   = bcd($urandom_range(0, 59));
    sc   = bcd($urandom_range(0, 59));
    sync = 1'($urandom_range(0, 1));
    err  = 1'($urandom_range(0, 1));
  endtask

  task automatic build_pkt();
    pkt4[0] = yr; pkt4[1] = mo; pkt4[2] = dy;
    pkt4[3] = {5'b0, dow};
    pkt4[4] = hr; pkt4[5] = mi; pkt4[6] = sc;
    pkt4[7] = {sync, err, 2'b00, 4'(m_seq % 16)};
    for (int i = 0; i < 7; i++) pkt2[i] = pkt4[i];
    pkt2[7] = {sync, err, 2'b00, 4'(m_seq % 4)};
  endtask

  task automatic step(input logic r, input logic rdy, input logic ab);
    if (churn) rand_time();
    rst = r; ready = rdy; abort = ab;
    if (!r) begin
      m_valid = 0; m_seq = 0; m_pos = 0; m_rst = 1;
    end else begin
      m_rst = 0;
      if (!m_valid) begin
        build_pkt();
        m_pos = 0; m_valid = 1;
      end else if (ab) begin
        m_pos = 0;
      end else if (rdy) begin
        if (m_pos == 7) begin
          m_seq++; m_valid = 0;
        end else m_pos++;
      end
    end
    @(posedge clk);
    @(negedge clk);
    check("valid4", valid4, m_valid);
    check("valid2", valid2, m_valid);
    check("crc4", crc4, m_valid && m_pos == 7);
    check("crc2", crc2, m_valid && m_pos == 7);
    if (m_valid) begin
      check("data4", data4, pkt4[m_pos]);
      check("data2", data2, pkt2[m_pos]);
    end
    if (m_rst) begin
      check("rst_data4", data4, 8'h00);
      check("rst_data2", data2, 8'h00);
    end
  endtask

  task automatic run_until_pos(input int p);
    int n = 0;
    while (!(m_valid && m_pos == p) && n < 40) begin
      step(1'b1, 1'b1, 1'b0);
      n++;
    end
    if (n >= 40) check("timeout", 1, 0);
  endtask

  logic [7:0] exp1 [8];

  initial begin
    exp1[0] = 8'h24; exp1[1] = 8'h03; exp1[2] = 8'h15; exp1[3] = 8'h05;
    exp1[4] = 8'h13; exp1[5] = 8'h45; exp1[6] = 8'h07; exp1[7] = 8'h80;
    yr = 8'h24; mo = 8'h03; dy = 8'h15; dow = 3'd5;
    hr = 8'h13; mi = 8'h45; sc = 8'h07; sync = 1'b1; err = 1'b0;
    abort = 1'b0; ready = 1'b0;
    @(negedge clk);

    // directed packet, fixed time
    repeat (3) step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 8; k++) begin
      check("t1_byte", data4, exp1[k]);
      check("t1_crc", crc4, k == 7);
      step(1'b1, 1'b1, 1'b0);
    end
    step(1'b1, 1'b1, 1'b0);
    repeat (7) step(1'b1, 1'b1, 1'b0);
    check("t1_status4", data4, 8'h81);
    check("t1_status2", data2, 8'h81);
    step(1'b1, 1'b1, 1'b0);

    // rollover while mid-packet
    sc = 8'h59; mi = 8'h59; hr = 8'h23;
    step(1'b1, 1'b1, 1'b0);
    run_until_pos(3);
    sc = 8'h00; mi = 8'h00; hr = 8'h00;
    repeat (14) step(1'b1, 1'b1, 1'b0);

    // aborts at idx 5 and on the last transfer
    churn = 1;
    run_until_pos(5);
    step(1'b1, 1'b1, 1'b1);
    run_until_pos(7);
    step(1'b1, 1'b1, 1'b1);
    run_until_pos(7);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);

    // 16+ clean packets for seq wrap
    churn = 0;
    repeat (18 * 9) step(1'b1, 1'b1, 1'b0);

    // reset mid-packet
    run_until_pos(4);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    run_until_pos(7);
    check("rst_seq4", data4[3:0], 4'h0);

    // random stalls, aborts and time churn
    churn = 1;
    for (int c = 0; c < 3000; c++) begin
      logic rdy;
      rdy = (stall == 0);
      if (stall > 0) stall--;
      else stall = $urandom_range(0, 5);
      step(1'b1, rdy, 1'($urandom_range(0, 39) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
